// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD up/down counter with clear, parallel load, wrap/saturate and sticky boundary flag.
// Optional macro BCD_CNT_LOAD_CHECK_EN clamps invalid load digits to 9 and flags them on ovf.
module bcd_multi_counter #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                  gclk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  borrow,
    output logic                  ovf
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_r;
    logic [W-1:0] next_count_s;
    logic [W-1:0] step_s;
    logic [W-1:0] load_val_s;
    logic         load_bad_s;
    logic         all_nine_s;
    logic         all_zero_s;
    logic         ovf_r;
    logic         next_ovf_s;

    // Ripple a +1/-1 through the digits; the final digit's outgoing carry/borrow is dropped (wrap).
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic dir_up);
        logic [W-1:0] r;
        logic         prop;
        r    = v;
        prop = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!prop) begin
                r[4*i +: 4] = v[4*i +: 4];
            end else if (dir_up) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    prop        = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    prop        = 1'b0;
                end
            end else begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    prop        = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    prop        = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_digits_are(input logic [W-1:0] v, input logic [3:0] d);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != d) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

`ifdef BCD_CNT_LOAD_CHECK_EN
    function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic any_digit_invalid(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign load_val_s = clamp_digits(din);
    assign load_bad_s = any_digit_invalid(din);
`else
    assign load_val_s = din;
    assign load_bad_s = 1'b0;
`endif

    assign all_nine_s = all_digits_are(count_r, 4'd9);
    assign all_zero_s = all_digits_are(count_r, 4'd0);
    assign step_s     = bcd_step(count_r, up);

    // Boundary indicators only fire when counting actually wins the priority this cycle.
    assign carry  = en &  up & ~clr & ~load & all_nine_s;
    assign borrow = en & ~up & ~clr & ~load & all_zero_s;

    // Next-state selection by priority: clear, load, count, hold.
    always_comb begin
        next_count_s = count_r;
        next_ovf_s   = ovf_r;
        if (clr) begin
            next_count_s = {W{1'b0}};
            next_ovf_s   = 1'b0;
        end else if (load) begin
            next_count_s = load_val_s;
            next_ovf_s   = ovf_r | load_bad_s;
        end else if (en) begin
            if (carry || borrow) begin
                next_ovf_s = 1'b1;
                if (WRAP != 0) begin
                    next_count_s = step_s;
                end else begin
                    next_count_s = count_r;
                end
            end else begin
                next_count_s = step_s;
                next_ovf_s   = ovf_r;
            end
        end else begin
            next_count_s = count_r;
            next_ovf_s   = ovf_r;
        end
    end

    // State registers; reset forces zero immediately, independent of the clock.
    always_ff @(posedge gclk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            count_r <= next_count_s;
            ovf_r   <= next_ovf_s;
        end
    end

    assign count = count_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed bench for bcd_multi_counter: a wrapping and a saturating instance share all inputs.
// Load-check expectations follow the BCD_CNT_LOAD_CHECK_EN macro.
module tb_bcd_multi_counter;

    logic        gclk;
    logic        reset;
    logic        clr;
    logic        load;
    logic [15:0] din;
    logic        en;
    logic        up;
    logic [15:0] count_w;
    logic        carry_w;
    logic        borrow_w;
    logic        ovf_w;
    logic [15:0] count_s;
    logic        carry_s;
    logic        borrow_s;
    logic        ovf_s;

    int checks;
    int errors;

    bcd_multi_counter #(.DIGITS(4), .WRAP(1)) dut_wrap (
        .gclk(gclk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en), .up(up),
        .count(count_w), .carry(carry_w), .borrow(borrow_w), .ovf(ovf_w)
    );

    bcd_multi_counter #(.DIGITS(4), .WRAP(0)) dut_sat (
        .gclk(gclk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en), .up(up),
        .count(count_s), .carry(carry_s), .borrow(borrow_s), .ovf(ovf_s)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr = 1'b0; load = 1'b0; din = 16'h0000; en = 1'b0; up = 1'b1;
        #3;
        checks++; if (count_w !== 16'h0000) begin errors++; $display("FAIL reset_count_w got %h want 0000", count_w); end
        checks++; if (count_s !== 16'h0000) begin errors++; $display("FAIL reset_count_s got %h want 0000", count_s); end
        checks++; if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b%b want 00", ovf_w, ovf_s); end
        checks++; if (carry_w !== 1'b0 || borrow_w !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", carry_w, borrow_w); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        load = 1'b1; din = 16'h0416;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++; if (count_w !== 16'h0417) begin errors++; $display("FAIL pre_reset_count got %h want 0417", count_w); end
        #2 reset = 1'b1;
        #1;
        checks++; if (count_w !== 16'h0000 || count_s !== 16'h0000) begin errors++; $display("FAIL async_reset_count got %h/%h want 0000", count_w, count_s); end
        checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL async_reset_ovf got %b want 0", ovf_w); end
        #1 reset = 1'b0; en = 1'b0;
        tick();
        checks++; if (count_w !== 16'h0000) begin errors++; $display("FAIL post_reset_hold got %h want 0000", count_w); end
    endtask

    task automatic test_count_up();
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'h0999; exp_seq[1] = 16'h1000; exp_seq[2] = 16'h1001;
        load = 1'b1; din = 16'h0998;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (carry_w !== 1'b0) begin errors++; $display("FAIL up_carry[%0d] got %b want 0", i, carry_w); end
            tick();
            checks++; if (count_w !== exp_seq[i]) begin errors++; $display("FAIL up_count[%0d] got %h want %h", i, count_w, exp_seq[i]); end
        end
        en = 1'b0;
        tick();
        checks++; if (count_w !== 16'h1001) begin errors++; $display("FAIL hold_count got %h want 1001", count_w); end
    endtask

    task automatic test_carry();
        load = 1'b1; din = 16'h9999;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        checks++; if (carry_w !== 1'b1 || carry_s !== 1'b1) begin errors++; $display("FAIL carry_assert got %b%b want 11", carry_w, carry_s); end
        checks++; if (borrow_w !== 1'b0) begin errors++; $display("FAIL carry_borrow got %b want 0", borrow_w); end
        tick();
        checks++; if (count_w !== 16'h0000 || ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_up got %h ovf %b want 0000 ovf 1", count_w, ovf_w); end
        checks++; if (count_s !== 16'h9999 || ovf_s !== 1'b1) begin errors++; $display("FAIL sat_up got %h ovf %b want 9999 ovf 1", count_s, ovf_s); end
        checks++; if (carry_w !== 1'b0 || carry_s !== 1'b1) begin errors++; $display("FAIL carry_after got %b%b want 01", carry_w, carry_s); end
        en = 1'b0;
        tick();
        checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_w); end
    endtask

    task automatic test_borrow();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (count_s !== 16'h0000 || ovf_s !== 1'b0) begin errors++; $display("FAIL clr_state got %h ovf %b want 0000 ovf 0", count_s, ovf_s); end
        en = 1'b1; up = 1'b0;
        #1;
        checks++; if (borrow_w !== 1'b1 || borrow_s !== 1'b1) begin errors++; $display("FAIL borrow_assert got %b%b want 11", borrow_w, borrow_s); end
        tick();
        checks++; if (count_s !== 16'h0000 || ovf_s !== 1'b1) begin errors++; $display("FAIL sat_down got %h ovf %b want 0000 ovf 1", count_s, ovf_s); end
        checks++; if (count_w !== 16'h9999 || ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_down got %h ovf %b want 9999 ovf 1", count_w, ovf_w); end
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (ovf_s !== 1'b0 || ovf_w !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b%b want 00", ovf_w, ovf_s); end
        load = 1'b1; din = 16'h1000;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        en = 1'b0;
        checks++; if (count_w !== 16'h0999) begin errors++; $display("FAIL down_ripple got %h want 0999", count_w); end
    endtask

    task automatic test_priority();
        load = 1'b1; din = 16'h9999;
        tick();
        clr = 1'b1; load = 1'b1; din = 16'h1234; en = 1'b1; up = 1'b1;
        #1;
        checks++; if (carry_w !== 1'b0) begin errors++; $display("FAIL clr_masks_carry got %b want 0", carry_w); end
        tick();
        checks++; if (count_w !== 16'h0000) begin errors++; $display("FAIL clr_priority got %h want 0000", count_w); end
        clr = 1'b0;
        tick();
        checks++; if (count_w !== 16'h1234) begin errors++; $display("FAIL load_priority got %h want 1234", count_w); end
        din = 16'h9999;
        tick();
        checks++; if (carry_w !== 1'b0) begin errors++; $display("FAIL load_masks_carry got %b want 0", carry_w); end
        tick();
        checks++; if (count_w !== 16'h9999 || ovf_w !== 1'b0) begin errors++; $display("FAIL load_no_ovf got %h ovf %b want 9999 ovf 0", count_w, ovf_w); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_load_check();
        clr = 1'b1;
        tick();
        clr = 1'b0; load = 1'b1; din = 16'h1A2F;
        tick();
        load = 1'b0;
`ifdef BCD_CNT_LOAD_CHECK_EN
        checks++; if (count_w !== 16'h1929 || ovf_w !== 1'b1) begin errors++; $display("FAIL load_clamp got %h ovf %b want 1929 ovf 1", count_w, ovf_w); end
`else
        checks++; if (count_w !== 16'h1A2F || ovf_w !== 1'b0) begin errors++; $display("FAIL load_raw got %h ovf %b want 1a2f ovf 0", count_w, ovf_w); end
`endif
        load = 1'b1; din = 16'h0123;
        tick();
        load = 1'b0;
        checks++; if (count_w !== 16'h0123) begin errors++; $display("FAIL load_valid got %h want 0123", count_w); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_async_reset();
        test_count_up();
        test_carry();
        test_borrow();
        test_priority();
        test_load_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_multi_counter.md
BCD_MULTI_COUNTER -- requirements
Module: bcd_multi_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits (1..8).
REQ-002 SHALL have parameter WRAP, default 1; 1 = wrap at the count boundary, 0 = saturate.
REQ-003 SHALL have port gclk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous clear to zero.
REQ-006 SHALL have port load  input  1  synchronous parallel load from din.
REQ-007 SHALL have port din  input  4*DIGITS  load value; digit 0 (least significant) in bits [3:0].
REQ-008 SHALL have port en  input  1  count enable; one step per enabled cycle.
REQ-009 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-010 SHALL have port count  output  4*DIGITS  registered BCD value, same digit order as din.
REQ-011 SHALL have port carry  output  1  combinational; asserted when the next step would pass 99..9 going up.
REQ-012 SHALL have port borrow  output  1  combinational; asserted when the next step would pass 00..0 going down.
REQ-013 SHALL have port ovf  output  1  registered sticky boundary flag.

Function
REQ-014 SHALL apply one action per rising edge, by priority: clr, then load, then en; otherwise hold.
REQ-015 SHALL set count and ovf to 0 on clr, regardless of load and en.
REQ-016 SHALL copy din into count on load, with clr low; en SHALL be ignored in that cycle.
REQ-017 SHALL, on en with up=1, add 1 to digit 0; a digit at 9 SHALL become 0 and propagate +1 to the next digit, all within the same cycle.
REQ-018 SHALL, on en with up=0, subtract 1 from digit 0; a digit at 0 SHALL become 9 and propagate -1 to the next digit, all within the same cycle.
REQ-019 SHALL assert carry iff en=1, up=1, clr=0, load=0, and every digit equals 9.
REQ-020 SHALL assert borrow iff en=1, up=0, clr=0, load=0, and every digit equals 0.
REQ-021 SHALL, with WRAP=1, move count from 99..9 to 00..0 on carry and from 00..0 to 99..9 on borrow.
REQ-022 SHALL, with WRAP=0, hold count on carry or borrow; carry or borrow SHALL still assert.
REQ-023 SHALL set ovf to 1 on the edge at which carry or borrow is asserted; ovf SHALL clear only on clr or reset.
REQ-024 SHALL keep every digit of count in the range 0..9 at all times, given valid din.
REQ-025 SHALL have a latency of one gclk edge from any input to count; carry and borrow SHALL have zero latency.

Reset
REQ-026 SHALL immediately force count=0 and ovf=0 while reset=1, independent of gclk.
REQ-027 SHALL resume counting on the first rising edge after reset deasserts; reset mid-step SHALL abort the step with no partial update.

Configuration
REQ-028 SHALL define the macro BCD_CNT_LOAD_CHECK_EN, which adds load validation.
REQ-029 SHALL, when BCD_CNT_LOAD_CHECK_EN is defined, clamp any din digit above 9 to 9 on load and set ovf to 1 in the same edge.
REQ-030 SHALL, when BCD_CNT_LOAD_CHECK_EN is undefined, load din unmodified; counting from an invalid digit is then undefined, and ovf SHALL be unaffected by load.

Verification (DIGITS=4)
REQ-031 SHALL verify: reset pulse mid-count at 0x0417 -> count=0x0000 and ovf=0 immediately, without waiting for gclk.
REQ-032 SHALL verify: load 0x0998, then en=1, up=1 for 3 cycles -> count 0x0999, 0x1000, 0x1001; carry stays low throughout.
REQ-033 SHALL verify: WRAP=1, count=0x9999, en=1, up=1 -> carry=1 in that cycle; next count=0x0000 and ovf=1.
REQ-034 SHALL verify: WRAP=0, count=0x0000, en=1, up=0 -> borrow=1, count holds 0x0000, ovf=1; then clr -> ovf=0.
REQ-035 SHALL verify: clr, load (din=0x1234) and en all high in one cycle -> count=0x0000; load and en together -> count=0x1234.
REQ-036 SHALL verify: with BCD_CNT_LOAD_CHECK_EN defined, load din=0x1A2F -> count=0x1929 and ovf=1.
